sparvec_pack: RTL and testbench
===============================

# sparvec_pack

Dense-to-sparse vector packer for the SDitH GF(256) datapath. It scans a dense GF(256) vector held in a PROC_SIZE-wide word memory. For every nonzero byte it writes one `{loc, value}` entry, in increasing `loc` order, into the sparse-vector memory that `mat_sparvec_mul` consumes. It then pads the entry list with zero entries up to VEC_WEIGHT, so the multiplier always processes exactly VEC_WEIGHT entries.

## Interface
Parameters:
- PARAMETER_SET, "L3": selects defaults ("L1", "L2", "L3", anything else = tiny test set).
- VEC_SIZE_BYTES, 126/193/278/8: dense vector length in bytes.
- VEC_WEIGHT, 79/120/150/3: sparse entry capacity.
- N_GF, 8: bytes per memory word.
- PROC_SIZE, N_GF*8: memory word width.
- N_WORDS, ceil(VEC_SIZE_BYTES/N_GF): dense words scanned.
- LOC_W, CLOG2(VEC_SIZE_BYTES): location field width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  start pulse; sampled only in IDLE
- o_dense_rd  out  1  dense memory read enable
- o_dense_addr  out  CLOG2(N_WORDS)  dense word address
- i_dense  in  PROC_SIZE  dense read data; valid 1 cycle after o_dense_rd
- o_sp_wen  out  1  sparse entry write enable
- o_sp_addr  out  CLOG2(VEC_WEIGHT)+1  entry index
- o_sp_data  out  LOC_W+8  entry `{loc[LOC_W-1:0], value[7:0]}`
- o_weight  out  CLOG2(VEC_WEIGHT)+1  nonzero entries written (saturates at VEC_WEIGHT)
- o_overflow  out  1  sticky; more than VEC_WEIGHT nonzeros found
- o_busy  out  1  high in any state other than IDLE
- o_done  out  1  one-cycle completion pulse

## Operation
- **Byte mapping.** Word k, lane i (i=0 at bits [PROC_SIZE-1:PROC_SIZE-8]) holds vector byte k*N_GF+i. Lanes with index ≥ VEC_SIZE_BYTES in the last word are masked off regardless of content.
- **States.** IDLE → FETCH → WAIT → SCAN → (FETCH | PAD | DONE) → IDLE.
- **IDLE.** On i_start: clear o_weight, o_overflow and the word counter, then go to FETCH. i_start is ignored in all other states.
- **FETCH.** o_dense_rd=1, o_dense_addr=word counter.
- **WAIT.** Capture i_dense into the word register. Capture the lane mask, i.e. nonzero bytes AND valid lanes.
- **SCAN, per cycle:**
  - If the mask is nonzero, pick the lowest-index set lane. Drive o_sp_wen=1, o_sp_addr=o_weight, o_sp_data={k*N_GF+lane, byte}. Clear that mask bit and increment o_weight.
  - If the mask is empty: if the word counter < N_WORDS-1, increment it and go to FETCH. Otherwise go to PAD, or to DONE if o_weight==VEC_WEIGHT.
- **Overflow.** A nonzero byte picked while o_weight==VEC_WEIGHT is not written. It sets o_overflow, and the scan stops and goes directly to DONE.
- **PAD.** Write {0,0} at o_sp_addr=o_weight, increment o_weight, one per cycle, until o_weight==VEC_WEIGHT. o_weight then reports the total entries written. The nonzero count is latched separately and is what is held on o_weight after DONE.
- **DONE.** o_done=1 for one cycle, then IDLE. o_weight (nonzero count) and o_overflow hold until the next start.

## Timing
- **Reset.** All outputs are 0 and the state is IDLE. i_rst mid-operation aborts on the next edge with no further writes. Sparse memory contents are then undefined.
- **Outputs.** o_dense_rd/o_dense_addr are registered state outputs. o_sp_* are driven from registers in the same SCAN/PAD cycle, and the sparse memory writes on that cycle's closing edge.
- **Latency.** Per word: nnz+3 cycles (FETCH, WAIT, nnz emitting SCAN cycles, 1 empty SCAN cycle). Total = Σ(nnz_k+3) + (VEC_WEIGHT−nnz) PAD cycles + 1 DONE cycle.
- **Ordering.** Entries are strictly increasing in loc, so the multiplier's addressing is monotonic.
- The block never reads and writes the same memory. The dense and sparse memories are independent ports.

## Structure
- Package `sdith_sparvec_pkg`: parameter-set lookup functions (VEC_SIZE_BYTES, VEC_WEIGHT), LOC_W, entry width, state encoding constants. The package is shared with `mat_sparvec_mul`.
- Sub-module `sparvec_lane_pick`: combinational N_GF-lane lowest-index priority encoder. It takes the mask and returns lane index plus any-set flag.

## Test plan
- **Tiny set, all-zero vector.** Start at edge 0 → FETCH cycle 1, SCAN cycle 3, PAD writes {0,0} at addr 0,1,2 in cycles 4–6, o_done in cycle 7; o_weight=0, o_overflow=0.
- **Tiny set, bytes [00,5A,00,00,11,00,00,FF].** Writes {1,5A}@0, {4,11}@1, {7,FF}@2, no PAD cycles; o_weight=3.
- **Tiny set, nonzeros at lanes 0,2,3,6.** Writes lanes 0,2,3 only; o_overflow=1, o_weight=3, o_done asserted.
- **L3, nonzeros at loc 0 (0x01) and 277 (0x80); lanes 278–279 of word 34 = 0xFF.** Writes {0,01}@0, {277,80}@1, then 148 pad entries; lanes 278–279 are never emitted.
- **Reset asserted during SCAN with two entries pending.** The next cycle has all outputs 0 and no writes. A fresh start then completes correctly.
- **i_start pulsed while busy is ignored.** Two back-to-back runs: the overflow from the first run is cleared by the second start.

Source files
------------

// File: rtl/sdith_sparvec_pkg.sv
// Shared definitions for the SDitH sparse-vector datapath (packer and multiplier):
// parameter-set lookups, field widths and the packer state encoding.
package sdith_sparvec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SCAN  = 3'd3,
    ST_PAD   = 3'd4,
    ST_DONE  = 3'd5
  } sparvec_state_t;

  // Dense vector length in bytes for a named parameter set; unknown names give the tiny set.
  function automatic int set_vec_size_bytes(input string ps);
    if (ps == "L1") return 126;
    if (ps == "L2") return 193;
    if (ps == "L3") return 278;
    return 8;
  endfunction

  // Sparse entry capacity for a named parameter set.
  function automatic int set_vec_weight(input string ps);
    if (ps == "L1") return 79;
    if (ps == "L2") return 120;
    if (ps == "L3") return 150;
    return 3;
  endfunction

  // Address width that never collapses to zero bits (a single-word memory still needs a port).
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Location field width for a vector of the given byte length.
  function automatic int loc_width(input int vec_size_bytes);
    return clog2_min1(vec_size_bytes);
  endfunction

  // Width of one {loc, value} sparse entry.
  function automatic int entry_width(input int loc_w);
    return loc_w + 8;
  endfunction

endpackage

// File: rtl/sparvec_lane_pick.sv
// Lowest-index priority encoder over the per-lane nonzero mask.
module sparvec_lane_pick
  import sdith_sparvec_pkg::*;
#(
  parameter int N_LANES = 8,
  localparam int LANE_W = clog2_min1(N_LANES)
) (
  input  logic [N_LANES-1:0] mask,
  output logic [LANE_W-1:0]  lane,
  output logic               any_set
);

  // Walk from the top lane down so the lowest set lane is the last one to win.
  always_comb begin
    lane = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (mask[i]) lane = LANE_W'(i);
    end
  end

  assign any_set = |mask;

endmodule

// File: rtl/sparvec_pack.sv
// Dense GF(256) vector to sparse {loc, value} list packer, zero-padded to VEC_WEIGHT entries.
module sparvec_pack
  import sdith_sparvec_pkg::*;
#(
  parameter string PARAMETER_SET  = "L3",
  parameter int    VEC_SIZE_BYTES = set_vec_size_bytes(PARAMETER_SET),
  parameter int    VEC_WEIGHT     = set_vec_weight(PARAMETER_SET),
  parameter int    N_GF           = 8,
  parameter int    PROC_SIZE      = N_GF * 8,
  parameter int    N_WORDS        = (VEC_SIZE_BYTES + N_GF - 1) / N_GF,
  parameter int    LOC_W          = loc_width(VEC_SIZE_BYTES),
  localparam int   DADDR_W        = clog2_min1(N_WORDS),
  localparam int   SADDR_W        = $clog2(VEC_WEIGHT) + 1,
  localparam int   ENTRY_W        = entry_width(LOC_W),
  localparam int   LANE_W         = clog2_min1(N_GF)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  output logic                 o_dense_rd,
  output logic [DADDR_W-1:0]   o_dense_addr,
  input  logic [PROC_SIZE-1:0] i_dense,
  output logic                 o_sp_wen,
  output logic [SADDR_W-1:0]   o_sp_addr,
  output logic [ENTRY_W-1:0]   o_sp_data,
  output logic [SADDR_W-1:0]   o_weight,
  output logic                 o_overflow,
  output logic                 o_busy,
  output logic                 o_done
);

  sparvec_state_t     state_reg, state_next;
  logic [DADDR_W-1:0] word_cnt_reg, word_cnt_next;
  logic [SADDR_W-1:0] weight_reg, weight_next;
  logic [SADDR_W-1:0] nnz_reg, nnz_next;
  logic               overflow_reg, overflow_next;
  logic [PROC_SIZE-1:0] word_reg, word_next;
  logic [N_GF-1:0]    mask_reg, mask_next;
  logic               dense_rd_reg;
  logic [DADDR_W-1:0] dense_addr_reg;

  logic [N_GF-1:0]    raw_mask;
  logic [7:0]         word_byte [N_GF];
  logic [LANE_W-1:0]  pick_lane;
  logic               pick_any;
  logic               sp_wen;
  logic [ENTRY_W-1:0] sp_data;
  logic               weight_full;

  // Lane gi sits in the top byte for gi=0; lanes past the end of the vector never count.
  generate
    for (genvar gi = 0; gi < N_GF; gi++) begin : g_lane
      assign word_byte[gi] = word_reg[PROC_SIZE-1-8*gi -: 8];
      assign raw_mask[gi]  = (i_dense[PROC_SIZE-1-8*gi -: 8] != 8'h00) &&
                             ((int'(word_cnt_reg) * N_GF + gi) < VEC_SIZE_BYTES);
    end
  endgenerate

  sparvec_lane_pick #(.N_LANES(N_GF)) u_pick (
    .mask    (mask_reg),
    .lane    (pick_lane),
    .any_set (pick_any)
  );

  assign weight_full = (weight_reg == SADDR_W'(VEC_WEIGHT));

  // Next-state and entry-emission logic; all outputs derive from registered state only.
  always_comb begin
    state_next    = state_reg;
    word_cnt_next = word_cnt_reg;
    weight_next   = weight_reg;
    nnz_next      = nnz_reg;
    overflow_next = overflow_reg;
    word_next     = word_reg;
    mask_next     = mask_reg;
    sp_wen        = 1'b0;
    sp_data       = '0;
    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          weight_next   = '0;
          nnz_next      = '0;
          overflow_next = 1'b0;
          word_cnt_next = '0;
          state_next    = ST_FETCH;
        end
      end
      ST_FETCH: state_next = ST_WAIT;
      ST_WAIT: begin
        word_next  = i_dense;
        mask_next  = raw_mask;
        state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (pick_any) begin
          if (weight_full) begin
            // No room for this nonzero: flag it and abandon the rest of the vector.
            overflow_next = 1'b1;
            nnz_next      = weight_reg;
            state_next    = ST_DONE;
          end else begin
            sp_wen      = 1'b1;
            sp_data     = {LOC_W'(int'(word_cnt_reg) * N_GF + int'(pick_lane)), word_byte[pick_lane]};
            mask_next   = mask_reg & ~(N_GF'(1) << pick_lane);
            weight_next = weight_reg + SADDR_W'(1);
          end
        end else if (word_cnt_reg < DADDR_W'(N_WORDS - 1)) begin
          word_cnt_next = word_cnt_reg + DADDR_W'(1);
          state_next    = ST_FETCH;
        end else begin
          nnz_next   = weight_reg;
          state_next = weight_full ? ST_DONE : ST_PAD;
        end
      end
      ST_PAD: begin
        sp_wen      = 1'b1;
        weight_next = weight_reg + SADDR_W'(1);
        if (weight_reg == SADDR_W'(VEC_WEIGHT - 1)) begin
          // Padding finished: report the nonzero count rather than the entry count.
          weight_next = nnz_reg;
          state_next  = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State and datapath registers; the dense read strobe is registered from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= ST_IDLE;
      word_cnt_reg   <= '0;
      weight_reg     <= '0;
      nnz_reg        <= '0;
      overflow_reg   <= 1'b0;
      word_reg       <= '0;
      mask_reg       <= '0;
      dense_rd_reg   <= 1'b0;
      dense_addr_reg <= '0;
    end else begin
      state_reg      <= state_next;
      word_cnt_reg   <= word_cnt_next;
      weight_reg     <= weight_next;
      nnz_reg        <= nnz_next;
      overflow_reg   <= overflow_next;
      word_reg       <= word_next;
      mask_reg       <= mask_next;
      dense_rd_reg   <= (state_next == ST_FETCH);
      dense_addr_reg <= word_cnt_next;
    end
  end

  assign o_dense_rd   = dense_rd_reg;
  assign o_dense_addr = dense_addr_reg;
  assign o_sp_wen     = sp_wen;
  assign o_sp_addr    = weight_reg;
  assign o_sp_data    = sp_data;
  assign o_weight     = weight_reg;
  assign o_overflow   = overflow_reg;
  assign o_busy       = (state_reg != ST_IDLE);
  assign o_done       = (state_reg == ST_DONE);

endmodule

// File: tb/tb_sparvec_pack.sv
// Bench for sparvec_pack: a tiny-set and an L3 instance against a queue-based reference list.
module tb_sparvec_pack;

  logic clk = 1'b0;
  logic rst;
  logic start_t, start_l;

  // tiny instance signals
  logic        rd_t;
  logic [0:0]  addr_t;
  logic [63:0] dq_t;
  logic        wen_t;
  logic [2:0]  spa_t;
  logic [10:0] spd_t;
  logic [2:0]  wt_t;
  logic        ovf_t, busy_t, done_t;

  // L3 instance signals
  logic        rd_l;
  logic [5:0]  addr_l;
  logic [63:0] dq_l;
  logic        wen_l;
  logic [8:0]  spa_l;
  logic [16:0] spd_l;
  logic [8:0]  wt_l;
  logic        ovf_l, busy_l, done_l;

  logic [63:0] mem_t [0:1];
  logic [63:0] mem_l [0:63];
  logic [7:0]  vec [0:279];

  int cap_t_a[$], cap_t_d[$], cap_l_a[$], cap_l_d[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sparvec_pack #(.PARAMETER_SET("TINY")) dut_t (
    .i_clk(clk), .i_rst(rst), .i_start(start_t),
    .o_dense_rd(rd_t), .o_dense_addr(addr_t), .i_dense(dq_t),
    .o_sp_wen(wen_t), .o_sp_addr(spa_t), .o_sp_data(spd_t),
    .o_weight(wt_t), .o_overflow(ovf_t), .o_busy(busy_t), .o_done(done_t)
  );

  sparvec_pack #(.PARAMETER_SET("L3")) dut_l (
    .i_clk(clk), .i_rst(rst), .i_start(start_l),
    .o_dense_rd(rd_l), .o_dense_addr(addr_l), .i_dense(dq_l),
    .o_sp_wen(wen_l), .o_sp_addr(spa_l), .o_sp_data(spd_l),
    .o_weight(wt_l), .o_overflow(ovf_l), .o_busy(busy_l), .o_done(done_l)
  );

  // Dense memories: one-cycle registered read
  always @(posedge clk) begin
    if (rd_t) dq_t <= mem_t[addr_t];
    if (rd_l) dq_l <= mem_l[addr_l];
  end

  // Sparse memory write capture, sampled mid-cycle
  always @(negedge clk) begin
    if (wen_t) begin cap_t_a.push_back(int'(spa_t)); cap_t_d.push_back(int'(spd_t)); end
    if (wen_l) begin cap_l_a.push_back(int'(spa_l)); cap_l_d.push_back(int'(spd_l)); end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_mem(input bit l3);
    int vs;
    vs = l3 ? 278 : 8;
    for (int w = 0; w < (vs + 7) / 8; w++) begin
      for (int i = 0; i < 8; i++) begin
        int loc;
        logic [7:0] b;
        loc = w * 8 + i;
        b = (loc < vs) ? vec[loc] : 8'hFF;   // garbage in lanes beyond the vector
        if (l3) mem_l[w][63-8*i -: 8] = b;
        else    mem_t[w][63-8*i -: 8] = b;
      end
    end
  endtask

  task automatic fill_random(input int vs, input int pct);
    for (int i = 0; i < 280; i++) vec[i] = 8'h00;
    for (int i = 0; i < vs; i++)
      if ($urandom_range(99) < pct) vec[i] = 8'($urandom_range(255, 1));
  endtask

  // One complete pack operation, checked against the list derived from vec[]
  task automatic do_run(input bit l3, input bit poke, input string tag);
    int vs, vw, cnt, lat, n, nwr, ovf, wt, ov, dn, bz;
    bit got_done;
    int exp_a[$];
    int exp_d[$];
    vs = l3 ? 278 : 8;
    vw = l3 ? 150 : 3;
    load_mem(l3);
    // reference: nonzeros in loc order, cut at capacity, then zero padding
    cnt = 0; ovf = 0; lat = 1;
    for (int w = 0; w < (vs + 7) / 8; w++) begin
      lat += 3;
      for (int i = 0; i < 8; i++) begin
        int loc;
        loc = w * 8 + i;
        if (loc < vs && vec[loc] != 8'h00 && ovf == 0) begin
          if (cnt == vw) ovf = 1;
          else begin
            exp_a.push_back(cnt);
            exp_d.push_back(loc * 256 + int'(vec[loc]));
            cnt++;
            lat++;
          end
        end
      end
    end
    if (ovf == 0) begin
      lat += vw - cnt;
      for (int a = cnt; a < vw; a++) begin exp_a.push_back(a); exp_d.push_back(0); end
    end
    cap_t_a.delete(); cap_t_d.delete(); cap_l_a.delete(); cap_l_d.delete();

    @(negedge clk);
    if (l3) start_l = 1'b1; else start_t = 1'b1;
    n = 0; got_done = 0;
    while (n < 2000 && !got_done) begin
      @(negedge clk);
      n++;
      start_t = 1'b0; start_l = 1'b0;
      if (poke && n == 2) begin
        if (l3) start_l = 1'b1; else start_t = 1'b1;   // must be ignored while busy
      end
      dn = l3 ? int'(done_l) : int'(done_t);
      if (dn == 1) got_done = 1;
    end
    start_t = 1'b0; start_l = 1'b0;
    check({tag, "/done_seen"}, int'(got_done), 1);
    if (ovf == 0) check({tag, "/latency"}, n, lat);
    nwr = l3 ? cap_l_a.size() : cap_t_a.size();
    check({tag, "/n_writes"}, nwr, exp_a.size());
    for (int k = 0; k < nwr && k < exp_a.size(); k++) begin
      check($sformatf("%s/addr[%0d]", tag, k), l3 ? cap_l_a[k] : cap_t_a[k], exp_a[k]);
      check($sformatf("%s/data[%0d]", tag, k), l3 ? cap_l_d[k] : cap_t_d[k], exp_d[k]);
    end
    wt = l3 ? int'(wt_l) : int'(wt_t);
    ov = l3 ? int'(ovf_l) : int'(ovf_t);
    check({tag, "/weight"}, wt, cnt);
    check({tag, "/overflow"}, ov, ovf);
    @(negedge clk);
    wt = l3 ? int'(wt_l) : int'(wt_t);
    ov = l3 ? int'(ovf_l) : int'(ovf_t);
    bz = l3 ? int'(busy_l | done_l) : int'(busy_t | done_t);
    check({tag, "/idle_after"}, bz, 0);
    check({tag, "/weight_hold"}, wt, cnt);
    check({tag, "/overflow_hold"}, ov, ovf);
    $display("run %s: nnz=%0d overflow=%0d cycles=%0d writes=%0d", tag, cnt, ovf, n, nwr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pct_tab [4];
    pct_tab[0] = 3; pct_tab[1] = 40; pct_tab[2] = 54; pct_tab[3] = 62;
    rst = 1'b1; start_t = 1'b0; start_l = 1'b0;
    for (int i = 0; i < 280; i++) vec[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_tiny", int'(|{rd_t, addr_t, wen_t, spa_t, spd_t, wt_t, ovf_t, busy_t, done_t}), 0);
    check("reset_l3", int'(|{rd_l, addr_l, wen_l, spa_l, spd_l, wt_l, ovf_l, busy_l, done_l}), 0);
    rst = 1'b0;

    // tiny: all zero -> three pad entries, done in cycle 7
    do_run(0, 0, "t_zero");
    // tiny: exactly VEC_WEIGHT nonzeros, stray start while busy
    vec[1] = 8'h5A; vec[4] = 8'h11; vec[7] = 8'hFF;
    do_run(0, 1, "t_exact");
    // tiny: four nonzeros -> overflow after three writes
    for (int i = 0; i < 8; i++) vec[i] = 8'h00;
    vec[0] = 8'h21; vec[2] = 8'h43; vec[3] = 8'h65; vec[6] = 8'h87;
    do_run(0, 0, "t_ovf");
    // back-to-back: the new start clears the previous overflow
    for (int i = 0; i < 8; i++) vec[i] = 8'h00;
    vec[1] = 8'h5A; vec[4] = 8'h11; vec[7] = 8'hFF;
    do_run(0, 0, "t_b2b");

    // reset in SCAN after the first of three entries
    for (int i = 0; i < 8; i++) vec[i] = 8'h00;
    vec[1] = 8'h11; vec[3] = 8'h22; vec[5] = 8'h33;
    load_mem(0);
    cap_t_a.delete(); cap_t_d.delete();
    @(negedge clk); start_t = 1'b1;
    @(negedge clk); start_t = 1'b0;
    n = 0;
    while (!(wen_t && spa_t == 3'd0) && n < 50) begin @(negedge clk); n++; end
    check("rst_mid/reached_scan", int'(wen_t), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid/outputs_zero", int'(|{rd_t, addr_t, wen_t, spa_t, spd_t, wt_t, ovf_t, busy_t, done_t}), 0);
    check("rst_mid/writes", cap_t_a.size(), 1);
    rst = 1'b0;
    do_run(0, 0, "t_after_rst");

    // L3: first and last locations, masked garbage lanes 278-279
    for (int i = 0; i < 280; i++) vec[i] = 8'h00;
    vec[0] = 8'h01; vec[277] = 8'h80;
    do_run(1, 1, "l3_edge");

    // randomized vectors
    for (int r = 0; r < 6; r++) begin
      fill_random(8, 45);
      do_run(0, r[0], $sformatf("t_rand%0d", r));
    end
    for (int r = 0; r < 6; r++) begin
      fill_random(278, pct_tab[r % 4]);
      do_run(1, 0, $sformatf("l3_rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
